// File: rtl/data_chpack_pkg.sv
// Shared constants and mode arithmetic for the channel packer.
// Used by data_chpack and data_chpack_acc.
package data_chpack_pkg;

    // Largest mode any supported lane count can need (CH_COUNT up to 16).
    localparam int unsigned MAX_MODE_LIMIT = 32'd4;

    function automatic int unsigned mode_clamp(input int unsigned mode, input int unsigned max_mode);
        if (mode > max_mode) begin
            return max_mode;
        end else begin
            return mode;
        end
    endfunction

    function automatic int unsigned beats_per_word(input int unsigned mode, input int unsigned max_mode);
        return 32'd1 << (max_mode - mode_clamp(mode, max_mode));
    endfunction

    function automatic int unsigned fill_count(input int unsigned pos, input int unsigned mode);
        return (pos + 32'd1) << mode;
    endfunction

endpackage

// File: rtl/data_chpack_acc.sv
// Lane accumulator for data_chpack: each accepted beat lands in lane group pos.
// With DATA_CHPACK_ZERO_FILL_EN defined the accumulator clears whenever a word closes.
module data_chpack_acc
    import data_chpack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CH_COUNT   = 8,
    parameter int unsigned POS_WIDTH  = 3,
    parameter int unsigned MODE_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic                           close,
    input  logic [POS_WIDTH-1:0]           pos,
    input  logic [MODE_WIDTH-1:0]          mode,
    input  logic [CH_COUNT*DATA_WIDTH-1:0] lanes,
    output logic [CH_COUNT*DATA_WIDTH-1:0] merged
);

    logic [CH_COUNT*DATA_WIDTH-1:0] acc_r;
    logic [CH_COUNT-1:0]            lane_we_s;
    int unsigned                    src_s;

    // Decode the lane group of this beat and overlay the incoming lanes on the accumulator.
    always_comb begin
        lane_we_s = {CH_COUNT{1'b0}};
        merged    = acc_r;
        src_s     = 32'd0;
        for (int unsigned l = 0; l < CH_COUNT; l++) begin
            if ((l >> mode) == 32'(pos)) begin
                lane_we_s[l] = 1'b1;
            end else begin
                lane_we_s[l] = 1'b0;
            end
        end
        for (int unsigned l = 0; l < CH_COUNT; l++) begin
            src_s = l & ((32'd1 << mode) - 32'd1);
            if (lane_we_s[l]) begin
                merged[l*DATA_WIDTH +: DATA_WIDTH] = lanes[src_s*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                merged[l*DATA_WIDTH +: DATA_WIDTH] = acc_r[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Accumulator storage; a closing beat goes straight to the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {(CH_COUNT*DATA_WIDTH){1'b0}};
        end else if (wr_en && !close) begin
            acc_r <= merged;
`ifdef DATA_CHPACK_ZERO_FILL_EN
        end else if (wr_en && close) begin
            acc_r <= {(CH_COUNT*DATA_WIDTH){1'b0}};
`endif
        end
    end

endmodule

// File: rtl/data_chpack.sv
// Channel packer: folds 2^cfg_mode active lanes per input beat into full CH_COUNT-lane words.
// Build macro DATA_CHPACK_ZERO_FILL_EN zeroes lanes at or above m_out_fill in flushed partial words.
module data_chpack
    import data_chpack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CH_COUNT    = 8,
    parameter int unsigned TAG_WIDTH   = 1,
    parameter int unsigned _MODE_WIDTH = $clog2($clog2(CH_COUNT) + 1),
    parameter int unsigned _FILL_WIDTH = $clog2(CH_COUNT) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [_MODE_WIDTH-1:0]         cfg_mode,
    input  logic [CH_COUNT*DATA_WIDTH-1:0] s_in_data,
    input  logic [TAG_WIDTH-1:0]           s_in_tag,
    input  logic                           s_in_valid,
    input  logic                           s_in_last,
    output logic                           s_in_ready,
    output logic [CH_COUNT*DATA_WIDTH-1:0] m_out_data,
    output logic [TAG_WIDTH-1:0]           m_out_tag,
    output logic [_FILL_WIDTH-1:0]         m_out_fill,
    output logic                           m_out_valid,
    output logic                           m_out_last,
    input  logic                           m_out_ready
);

    localparam int unsigned MAX_MODE  = $clog2(CH_COUNT);
    localparam int unsigned POS_WIDTH = MAX_MODE;
    localparam int unsigned BUS_WIDTH = CH_COUNT * DATA_WIDTH;

    logic [POS_WIDTH-1:0]   pos_r;
    logic [_MODE_WIDTH-1:0] mode_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [_MODE_WIDTH-1:0] eff_mode_s;
    logic [POS_WIDTH-1:0]   last_pos_s;
    logic [TAG_WIDTH-1:0]   first_tag_s;
    logic [_FILL_WIDTH-1:0] fill_s;
    logic                   s_in_ready_s;
    logic                   accept_s;
    logic                   close_s;
    logic [BUS_WIDTH-1:0]   merged_s;

    // Handshake and word-boundary decode; the mode is taken live only on the first beat of a word.
    always_comb begin
        s_in_ready_s = !m_out_valid || m_out_ready;
        accept_s     = s_in_valid && s_in_ready_s;
        if (pos_r == {POS_WIDTH{1'b0}}) begin
            eff_mode_s  = _MODE_WIDTH'(mode_clamp(32'(cfg_mode), MAX_MODE));
            first_tag_s = s_in_tag;
        end else begin
            eff_mode_s  = mode_r;
            first_tag_s = tag_r;
        end
        last_pos_s = POS_WIDTH'(beats_per_word(32'(eff_mode_s), MAX_MODE) - 32'd1);
        fill_s     = _FILL_WIDTH'(fill_count(32'(pos_r), 32'(eff_mode_s)));
        close_s    = accept_s && ((pos_r == last_pos_s) || s_in_last);
    end

    assign s_in_ready = s_in_ready_s;

    data_chpack_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .CH_COUNT   (CH_COUNT),
        .POS_WIDTH  (POS_WIDTH),
        .MODE_WIDTH (_MODE_WIDTH)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept_s),
        .close  (close_s),
        .pos    (pos_r),
        .mode   (eff_mode_s),
        .lanes  (s_in_data),
        .merged (merged_s)
    );

    // Slot pointer, latched mode and first-beat tag of the word in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_r  <= {POS_WIDTH{1'b0}};
            mode_r <= {_MODE_WIDTH{1'b0}};
            tag_r  <= {TAG_WIDTH{1'b0}};
        end else if (accept_s) begin
            if (close_s) begin
                pos_r <= {POS_WIDTH{1'b0}};
            end else begin
                pos_r <= pos_r + {{(POS_WIDTH-1){1'b0}}, 1'b1};
            end
            mode_r <= eff_mode_s;
            tag_r  <= first_tag_s;
        end
    end

    // Output word register: loads on a closing beat, drops valid once the word is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out_data  <= {BUS_WIDTH{1'b0}};
            m_out_tag   <= {TAG_WIDTH{1'b0}};
            m_out_fill  <= {_FILL_WIDTH{1'b0}};
            m_out_last  <= 1'b0;
            m_out_valid <= 1'b0;
        end else if (close_s) begin
            m_out_data  <= merged_s;
            m_out_tag   <= first_tag_s;
            m_out_fill  <= fill_s;
            m_out_last  <= s_in_last;
            m_out_valid <= 1'b1;
        end else if (m_out_ready) begin
            m_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_chpack.sv
// Randomized self-checking bench for data_chpack against a lane-list reference model.
// Honours DATA_CHPACK_ZERO_FILL_EN when checking lanes beyond the fill count.
module tb_data_chpack;

    localparam int DW  = 16;
    localparam int CH  = 8;
    localparam int MW  = 2;
    localparam int FW  = 4;
    localparam int BUS = CH * DW;
    localparam int LOG2CH = 3;

    typedef struct {
        logic [BUS-1:0] data;
        int             fill;
        logic           tag;
        logic           last;
    } word_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [MW-1:0]  cfg_mode;
    logic [BUS-1:0] s_in_data;
    logic [0:0]     s_in_tag;
    logic           s_in_valid;
    logic           s_in_last;
    logic           s_in_ready;
    logic [BUS-1:0] m_out_data;
    logic [0:0]     m_out_tag;
    logic [FW-1:0]  m_out_fill;
    logic           m_out_valid;
    logic           m_out_last;
    logic           m_out_ready;

    int n_vec = 0;
    int n_err = 0;

    word_t         exp_q[$];
    logic [DW-1:0] m_lanes[$];
    int            m_beats = 0;
    int            m_mode  = 0;
    logic          m_tag   = 1'b0;
    logic          exp_valid = 1'b0;

    data_chpack dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_mode    (cfg_mode),
        .s_in_data   (s_in_data),
        .s_in_tag    (s_in_tag),
        .s_in_valid  (s_in_valid),
        .s_in_last   (s_in_last),
        .s_in_ready  (s_in_ready),
        .m_out_data  (m_out_data),
        .m_out_tag   (m_out_tag),
        .m_out_fill  (m_out_fill),
        .m_out_valid (m_out_valid),
        .m_out_last  (m_out_last),
        .m_out_ready (m_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BUS-1:0] got, input logic [BUS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BUS-1:0] lane_mask(input int fill);
        logic [BUS-1:0] mk;
        mk = '0;
        for (int k = 0; k < CH; k++) begin
            if (k < fill) mk[k*DW +: DW] = '1;
`ifdef DATA_CHPACK_ZERO_FILL_EN
            else mk[k*DW +: DW] = '1;
`endif
        end
        return mk;
    endfunction

    function automatic logic [BUS-1:0] rand_bus();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: collect A samples per accepted beat; a word closes after CH/A beats or on last.
    task automatic model_beat(input logic [BUS-1:0] d, input logic t, input logic l,
                              input logic [MW-1:0] m, output logic closed);
        word_t w;
        int a;
        if (m_beats == 0) begin
            m_mode = (int'(m) > LOG2CH) ? LOG2CH : int'(m);
            m_tag  = t;
        end
        a = 1 << m_mode;
        for (int k = 0; k < a; k++) m_lanes.push_back(d[k*DW +: DW]);
        m_beats++;
        closed = (m_beats == (CH / a)) || l;
        if (closed) begin
            w.data = '0;
            for (int k = 0; k < m_lanes.size(); k++) w.data[k*DW +: DW] = m_lanes[k];
            w.fill = m_lanes.size();
            w.tag  = m_tag;
            w.last = l;
            exp_q.push_back(w);
            m_lanes.delete();
            m_beats = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_lanes.delete();
        m_beats   = 0;
        exp_valid = 1'b0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model, return after the edge.
    task automatic step(input logic v, input logic [BUS-1:0] d, input logic t, input logic l,
                        input logic [MW-1:0] m, input logic r, output logic acc);
        word_t w;
        logic  closed;
        s_in_valid  = v;
        s_in_data   = d;
        s_in_tag    = t;
        s_in_last   = l;
        cfg_mode    = m;
        m_out_ready = r;
        @(negedge clk);
        check_eq("s_in_ready", BUS'(s_in_ready), BUS'(!exp_valid || r));
        check_eq("m_out_valid", BUS'(m_out_valid), BUS'(exp_valid));
        if (exp_valid) begin
            check_eq("sb_nonempty", BUS'(exp_q.size() != 0), BUS'(1'b1));
            if (exp_q.size() != 0) begin
                w = exp_q[0];
                check_eq("m_out_data", m_out_data & lane_mask(w.fill), w.data & lane_mask(w.fill));
                check_eq("m_out_fill", BUS'(m_out_fill), BUS'(w.fill));
                check_eq("m_out_tag", BUS'(m_out_tag), BUS'(w.tag));
                check_eq("m_out_last", BUS'(m_out_last), BUS'(w.last));
                if (r) void'(exp_q.pop_front());
            end
        end
        acc = v && (!exp_valid || r);
        closed = 1'b0;
        if (acc) model_beat(d, t, l, m, closed);
        if (closed) exp_valid = 1'b1;
        else if (r) exp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS-1:0] two_lanes(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        logic [BUS-1:0] b;
        b = {$urandom, $urandom, $urandom, $urandom};
        b[DW-1:0]    = lo;
        b[2*DW-1:DW] = hi;
        return b;
    endfunction

    initial begin
        logic           acc;
        logic           pend;
        logic [BUS-1:0] d;
        logic           t, l, v, r;
        logic [MW-1:0]  m;
        logic [DW-1:0]  tp1[8];

        rst = 1'b0;
        cfg_mode = '0; s_in_data = '0; s_in_tag = '0; s_in_valid = 1'b0;
        s_in_last = 1'b0; m_out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_valid", BUS'(m_out_valid), '0);
        check_eq("rst_last", BUS'(m_out_last), '0);
        check_eq("rst_fill", BUS'(m_out_fill), '0);
        check_eq("rst_tag", BUS'(m_out_tag), '0);
        check_eq("rst_data", m_out_data, '0);
        rst = 1'b1;

        // mode 1: four beats fill one word
        tp1 = '{16'h10, 16'h11, 16'h20, 16'h21, 16'h30, 16'h31, 16'h40, 16'h41};
        for (int i = 0; i < 4; i++)
            step(1'b1, two_lanes(tp1[2*i], tp1[2*i+1]), (i == 0), 1'b0, 2'd1, 1'b1, acc);
        check_eq("tp1_data", m_out_data, 128'h0041_0040_0031_0030_0021_0020_0011_0010);
        check_eq("tp1_fill", BUS'(m_out_fill), BUS'(8));
        check_eq("tp1_tag", BUS'(m_out_tag), BUS'(1));

        // mode 0: last on third beat flushes a partial word
        step(1'b1, two_lanes(16'hA, 16'hFFFF), 1'b0, 1'b0, 2'd0, 1'b1, acc);
        step(1'b1, two_lanes(16'hB, 16'hFFFF), 1'b0, 1'b0, 2'd0, 1'b1, acc);
        step(1'b1, two_lanes(16'hC, 16'hFFFF), 1'b0, 1'b1, 2'd0, 1'b1, acc);
        check_eq("tp2_lanes", BUS'(m_out_data[3*DW-1:0]), BUS'(48'h000C_000B_000A));
        check_eq("tp2_fill", BUS'(m_out_fill), BUS'(3));
        check_eq("tp2_last", BUS'(m_out_last), BUS'(1));

        // mode 3: continuous valid, ready toggling; stalled beats are held
        begin
            int sent = 0;
            int cyc = 0;
            d = rand_bus();
            while (sent < 6 && cyc < 40) begin
                step(1'b1, d, cyc[0], 1'b0, 2'd3, (cyc % 2 == 0), acc);
                if (acc) begin sent++; d = rand_bus(); end
                cyc++;
            end
            check_eq("tp3_budget", BUS'(sent), BUS'(6));
        end

        // mode change 1 -> 2 at pos 1 only affects the next word
        step(1'b1, rand_bus(), 1'b1, 1'b0, 2'd1, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(1'b1, rand_bus(), 1'b0, 1'b0, 2'd2, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b0, 2'd2, 1'b1, acc);

        // asynchronous reset with two beats of a mode-1 word in progress
        step(1'b1, rand_bus(), 1'b1, 1'b0, 2'd1, 1'b1, acc);
        step(1'b1, rand_bus(), 1'b0, 1'b0, 2'd1, 1'b1, acc);
        s_in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("arst_valid", BUS'(m_out_valid), '0);
        check_eq("arst_fill", BUS'(m_out_fill), '0);
        check_eq("arst_data", m_out_data, '0);
        check_eq("arst_tag", BUS'(m_out_tag), '0);
        check_eq("arst_last", BUS'(m_out_last), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b1, rand_bus(), 1'b0, 1'b0, 2'd1, 1'b1, acc);
        check_eq("post_rst_fill", BUS'(m_out_fill), BUS'(8));

        // out-of-range mode truncates/clamps to pass-through
        d = rand_bus();
        step(1'b1, d, 1'b1, 1'b0, 2'(32'd7), 1'b1, acc);
        check_eq("clamp_data", m_out_data, d);
        check_eq("clamp_fill", BUS'(m_out_fill), BUS'(8));

        // randomized traffic with AXI-style hold of unaccepted beats
        pend = 1'b0;
        d = '0; t = 1'b0; l = 1'b0; m = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pend) begin
                d = rand_bus();
                t = 1'($urandom_range(0, 1));
                l = ($urandom_range(0, 7) == 0);
                m = 2'($urandom_range(0, 3));
            end
            v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            step(v, d, t, l, m, r, acc);
            pend = v && !acc;
        end
        // drain: close any partial word with a last beat, then empty the output
        for (int i = 0; i < 8 && (pend || m_beats != 0); i++) begin
            step(1'b1, d, t, 1'b1, m, 1'b1, acc);
            pend = !acc;
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, acc);
        check_eq("drain_empty", BUS'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
